// File: rtl/rf_tx_packet_drainer.sv
// Purpose: drains the TX byte FIFO into the UART in packets gated by the RF AUX pin.
// Latency: fifo_rd to tx_valid is 2 cycles; at least 3 cycles per byte; GAP_CYCLES idle after each packet.
// Backpressure: tx_valid/tx_data are held until tx_ready; no new pop until the current byte is accepted.
module rf_tx_packet_drainer #(
  parameter int WIDTH        = 8,
  parameter int MAX_PACKET   = 58,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int GAP_CYCLES   = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  input  logic             fifo_reach_limit,
  output logic             fifo_rd,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             aux,
  output logic             busy,
  output logic [7:0]       pkt_len
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [7:0]    PKT_MAX  = 8'(MAX_PACKET);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_AUX,
    S_POP,
    S_LATCH,
    S_SEND,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       pkt_len_q, pkt_len_d;
  logic [1:0]       aux_sync_q;
  logic [7:0]       byte_inc;
  logic             last_byte;

  // Count of bytes including the one being handed over now; byte_cnt never wraps since MAX_PACKET<=255.
  assign byte_inc  = byte_cnt_q + 8'd1;
  // A packet ends when it is full or when the FIFO has run dry at the handshake.
  assign last_byte = (byte_inc == PKT_MAX) || fifo_empty;

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign pkt_len  = pkt_len_q;
  assign busy     = (state_q != S_IDLE);

  // Two-flop synchroniser for the asynchronous AUX ready pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aux_sync_q <= 2'b00;
    end else begin
      aux_sync_q <= {aux_sync_q[0], aux};
    end
  end

  // Next-state and output decode for the packet FSM.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    pkt_len_d  = pkt_len_q;
    fifo_rd    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Idle counter measures how long data has been sitting below the limit.
        if (fifo_empty) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if (!fifo_empty && (fifo_reach_limit || (idle_cnt_q == IDLE_MAX))) begin
          idle_cnt_d = '0;
          state_d    = S_WAIT_AUX;
        end
      end
      S_WAIT_AUX: begin
        byte_cnt_d = 8'd0;
        if (aux_sync_q[1]) begin
          state_d = S_POP;
        end
      end
      S_POP: begin
        fifo_rd = !fifo_empty;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        // FIFO read data is valid now, one cycle after the pop.
        tx_data_d  = fifo_data;
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          byte_cnt_d = byte_inc;
          if (last_byte) begin
            pkt_len_d = byte_inc;
            state_d   = S_GAP;
          end else begin
            state_d = S_POP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any popped but unsent byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
      byte_cnt_q <= 8'd0;
      gap_cnt_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      pkt_len_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      pkt_len_q  <= pkt_len_d;
    end
  end

endmodule

// File: tb/tb_rf_tx_packet_drainer.sv
// Purpose: randomized self-checking bench for rf_tx_packet_drainer against a queue-based FIFO and byte scoreboard.
// Latency: models a FIFO whose read data appears the cycle after fifo_rd.
// Backpressure: tx_ready is driven always-high, random, stalled on byte 0x55, or held low.
module tb_rf_tx_packet_drainer;

  localparam int MAXP  = 58;
  localparam int TMO   = 1000;
  localparam int GAP   = 100;
  localparam int LIMIT = 58;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_reach_limit;
  logic       tx_ready = 1'b1;
  logic       aux;
  logic       fifo_rd;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic [7:0] pkt_len;

  rf_tx_packet_drainer #(
    .WIDTH(8), .MAX_PACKET(MAXP), .IDLE_TIMEOUT(TMO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_reach_limit(fifo_reach_limit), .fifo_rd(fifo_rd), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .aux(aux), .busy(busy), .pkt_len(pkt_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: fq is the FIFO contents, exp_q is every byte still owed to the UART, in order.
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];

  task automatic upd_flags();
    fifo_empty       = (fq.size() == 0);
    fifo_reach_limit = (fq.size() == LIMIT);
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
    upd_flags();
  endtask

  // FIFO model: a pop seen during a cycle presents its data just after the next rising edge.
  logic [7:0] nd;
  bit         have = 0;
  always begin
    @(negedge clk);
    if (fifo_rd && fq.size() != 0) begin
      nd   = fq.pop_front();
      have = 1;
    end
    @(posedge clk);
    #1;
    if (have) begin
      fifo_data = nd;
      have      = 0;
    end
    upd_flags();
  end

  // tx_ready driver: 0 always ready, 1 random, 2 stall 20 cycles on 0x55, 3 never ready.
  int rdy_mode = 0;
  int stall_n  = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (tx_valid && tx_data == 8'h55 && stall_n < 20) begin
          tx_ready = 1'b0;
          stall_n++;
        end else begin
          tx_ready = 1'b1;
        end
      end
      default: tx_ready = 1'b0;
    endcase
  end

  // Monitor: counts pops and transfers, scoreboards bytes, checks hold-while-stalled.
  int         rd_cnt = 0;
  int         hs_cnt = 0;
  int         hold_cnt = 0;
  logic       pv = 1'b0, pr = 1'b0, prst = 1'b0;
  logic [7:0] pd = 8'h00;
  always @(negedge clk) begin
    if (fifo_rd) begin
      rd_cnt++;
      check("rd_while_empty", fifo_empty, 1'b0);
    end
    if (rst_n && prst && pv && !pr) begin
      hold_cnt++;
      check("hold_valid", tx_valid, 1'b1);
      check("hold_data", tx_data, pd);
    end
    if (tx_valid && tx_ready) begin
      hs_cnt++;
      check("byte_owed", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("tx_byte", tx_data, exp_q.pop_front());
    end
    pv   = tx_valid;
    pr   = tx_ready;
    pd   = tx_data;
    prst = rst_n;
  end

  // Waits for the owed bytes to drain, then checks gap length, pkt_len and pop count.
  task automatic finish_pkt(input string tag, input int n, input int rd0);
    int t;
    int g;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk); #2;
      t++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    g = 0;
    while (busy && g < 400) begin
      g++;
      @(posedge clk); #2;
    end
    check({tag, "_gap"}, g, GAP);
    check({tag, "_pkt_len"}, pkt_len, n);
    check({tag, "_pops"}, rd_cnt - rd0, n);
  endtask

  initial begin
    int rd0, hs0, lat, n, t, drop, h0;
    rst_n     = 1'b0;
    aux       = 1'b1;
    fifo_data = 8'h00;
    upd_flags();

    // Reset with data waiting, then a timeout flush of three bytes.
    push(8'hA1); push(8'hA2); push(8'hA3);
    repeat (3) @(posedge clk);
    #2;
    check("rst_fifo_rd", fifo_rd, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_pkt_len", pkt_len, 8'd0);
    rst_n = 1'b1;
    rd0   = rd_cnt;
    lat   = 0;
    while (!fifo_rd && lat < 3000) begin
      @(posedge clk); #2;
      lat++;
    end
    // TMO edges to saturate, one to leave IDLE, one in WAIT_AUX.
    check("tmo_latency", lat, TMO + 2);
    finish_pkt("tmo", 3, rd0);

    // Limit trigger with an ascending pattern, always ready.
    rdy_mode = 0;
    rd0 = rd_cnt;
    for (int i = 0; i < 58; i++) push(8'(i));
    finish_pkt("limit", 58, rd0);

    // Random packet sizes and payloads with random backpressure.
    for (int k = 0; k < 4; k++) begin
      rdy_mode = 1;
      n   = $urandom_range(1, MAXP);
      rd0 = rd_cnt;
      for (int i = 0; i < n; i++) push(8'($urandom_range(0, 255)));
      finish_pkt("rand", n, rd0);
    end

    // AUX gating: held off for 500 cycles, then released; dropped mid-packet.
    rdy_mode = 0;
    aux = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rd0 = rd_cnt;
    for (int i = 0; i < 58; i++) push(8'($urandom_range(0, 255)));
    repeat (500) @(posedge clk);
    #2;
    check("aux_wait_busy", busy, 1'b1);
    check("aux_wait_pops", rd_cnt - rd0, 0);
    aux = 1'b1;
    lat = 0;
    while (!fifo_rd && lat < 50) begin
      @(posedge clk); #2;
      lat++;
    end
    check("aux_latency", lat, 3);
    hs0 = hs_cnt;
    t = 0;
    while (hs_cnt - hs0 < 10 && t < 500) begin
      @(posedge clk); #2;
      t++;
    end
    aux = 1'b0;
    finish_pkt("aux_drop", 58, rd0);
    aux = 1'b1;

    // Backpressure: 20-cycle stall on the 0x55 byte.
    rdy_mode = 2;
    stall_n  = 0;
    h0  = hold_cnt;
    rd0 = rd_cnt;
    for (int i = 0; i < 58; i++) push((i == 5) ? 8'h55 : 8'($urandom_range(0, 8'h54)));
    finish_pkt("bp", 58, rd0);
    check("bp_stall_cycles", stall_n, 20);
    check("bp_hold_checks", hold_cnt - h0, 20);

    // Asynchronous reset while a byte is stuck in SEND.
    rdy_mode = 0;
    hs0 = hs_cnt;
    for (int i = 0; i < 58; i++) push(8'($urandom_range(0, 255)));
    t = 0;
    while (hs_cnt - hs0 < 4 && t < 500) begin
      @(posedge clk); #2;
      t++;
    end
    rdy_mode = 3;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(tx_valid && !tx_ready) && t < 100);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx_valid", tx_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_fifo_rd", fifo_rd, 1'b0);
    drop = rd_cnt - hs_cnt;
    check("arst_dropped", drop, 1);
    for (int i = 0; i < drop; i++) void'(exp_q.pop_front());
    repeat (2) @(posedge clk);
    #2;
    rdy_mode = 0;
    rst_n = 1'b1;
    check("post_rst_pkt_len", pkt_len, 8'd0);
    check("post_rst_busy", busy, 1'b0);
    rd0 = rd_cnt;
    n = LIMIT - fq.size();
    for (int i = 0; i < n; i++) push(8'($urandom_range(0, 255)));
    finish_pkt("restart", 58, rd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall time bound in case the design stalls the flow indefinitely.
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
